dvb_s2x_dec_frame_mux: RTL and testbench
========================================

# dvb_s2x_dec_frame_mux

Parametrised N-channel, frame-level AXI-stream multiplexer in front of the DVB-S2/S2X decoder slave port. It arbitrates round-robin between channels at frame boundaries and locks to one channel until tlast. Each frame is tagged with its channel index on tid. Over-long frames are truncated and drained. Sits between per-demodulator LLR streams and the decoder core's s_axis input, in the decoder clock domain.

## Interface
- pN_CHAN, 4, number of input channels (2..16)
- pDAT_W, 32, tdata width per channel
- pUSER_W, 18, tuser width (frame descriptor, passed through)
- pDEST_W, 4, tdest width (passed through)
- pMAX_LEN, 4096, maximum words per frame before forced truncation (≥2)

- iclk  in  1  clock; single clock domain
- iresetn  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  pN_CHAN  per-channel valid
- s_axis_tdata  in  pN_CHAN*pDAT_W  packed data, channel k at [k*pDAT_W +: pDAT_W]
- s_axis_tlast  in  pN_CHAN  per-channel end of frame
- s_axis_tdest  in  pN_CHAN*pDEST_W  packed dest
- s_axis_tuser  in  pN_CHAN*pUSER_W  packed user; sampled on every word, passed through
- s_axis_tready  out  pN_CHAN  per-channel ready; at most one bit high
- m_axis_tready  in  1  decoder ready
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  pDAT_W  output data
- m_axis_tlast  out  1  end of frame (source tlast or forced)
- m_axis_tid  out  8  granted channel index, zero-extended
- m_axis_tdest  out  pDEST_W  dest of granted channel
- m_axis_tuser  out  pUSER_W  user of granted channel
- obusy  out  1  high whenever state ≠ IDLE or output buffer non-empty
- oframe_done  out  1  one-cycle pulse when a frame's last word (source or forced) is accepted at input
- oframe_chan  out  8  channel of the frame reported by oframe_done, held until the next pulse
- oframe_trunc  out  1  one-cycle pulse, coincident with oframe_done, when the frame was truncated

## Operation
- States: IDLE, PASS, DRAIN.
- IDLE: all s_axis_tready low. If any tvalid is high, grant the first requesting channel searching upward from (last_grant+1) mod pN_CHAN. Register the grant and go to PASS. Reset last_grant = pN_CHAN-1, so channel 0 has top priority after reset.
- PASS: s_axis_tready[grant] = buffer not full; other channels' tready are low.
  - Each accepted word increments word counter wcnt (starts at 0, width clog2(pMAX_LEN+1)).
  - Accepted word with tlast=1: pulse oframe_done, set last_grant=grant, clear wcnt, go to IDLE.
  - Accepted word with wcnt==pMAX_LEN-1 and tlast=0: forward it with m_axis_tlast forced to 1, pulse oframe_done+oframe_trunc, go to DRAIN.
- DRAIN: s_axis_tready[grant]=1 regardless of buffer state. Words are discarded and nothing is forwarded. The accepted word with tlast=1 sets last_grant, clears wcnt and goes to IDLE. It produces no oframe_done.
- A tlast word landing exactly at wcnt==pMAX_LEN-1 is a normal frame: no trunc, no DRAIN.
- tvalid dropping mid-frame keeps the lock; the arbiter never switches channels inside a frame.
- Output stage is a 2-entry skid buffer. It gives full throughput and registered m_axis outputs. "Full" means 2 entries are held.

## Timing
- Reset (async assert, sync release): m_axis_tvalid=0, all s_axis_tready=0, obusy=0, oframe_done=0, oframe_trunc=0, oframe_chan=0, m_axis_tdata/tlast/tid/tdest/tuser=0, state=IDLE, wcnt=0, buffer empty. A reset mid-frame drops buffered words without emitting tlast.
- Arbitration costs 1 cycle. Input word 0 can be accepted at T+1 when tvalid is seen at T in IDLE.
- Input-to-output latency is 1 cycle: a word accepted at T drives m_axis_tvalid at T+1.
- Frame turnaround: 1 idle input cycle between frames, including back-to-back frames from the same channel.
- Sustained throughput is 1 word/cycle while m_axis_tready=1.
- m_axis_tvalid/tdata/etc. are held stable while tvalid&&!tready.
- The input tready of the granted channel drops the cycle after the buffer reaches 2 entries.

## Structure
- Shared package dvb_s2x_dec_frame_mux_pkg holds:
  - state enum (IDLE/PASS/DRAIN);
  - function for next-requester round-robin search;
  - localparam cCHAN_W = clog2(pN_CHAN) rule.
- Sub-module dvb_s2x_axis_skid: parametrised-width 2-entry skid buffer (data = {tlast,tid,tdest,tuser,tdata}), also reused elsewhere.

## Test plan
- Single channel: ch2 sends 8-word frame, m_axis_tready=1.
  - Expected: 8 words out, tid=2, tlast on word 8, oframe_done once with oframe_chan=2, first output 2 cycles after the first tvalid.
- Round robin: ch0..ch3 all valid continuously, 4-word frames.
  - Expected: grant order 0,1,2,3,0, each frame contiguous.
- Backpressure: m_axis_tready toggles 1,0,0,1 pattern during a 16-word frame.
  - Expected: no word lost or duplicated, output stable while stalled, at most 2 words accepted during stall.
- Truncation: pMAX_LEN=4, ch1 sends a 7-word frame.
  - Expected: 4 words out with tlast on word 4, oframe_trunc pulse, words 5..7 discarded, ch1 tready high during DRAIN, next grant after tlast.
- Boundary: pMAX_LEN=4, 4-word frame with tlast on word 4.
  - Expected: no trunc, no DRAIN.
- Reset mid-frame: iresetn low after word 3 of 8.
  - Expected: all outputs 0 immediately; after release, ch0 wins first arbitration if valid.

Source files
------------

// File: rtl/dvb_s2x_dec_frame_mux_pkg.sv
// Shared definitions for the DVB-S2/S2X decoder frame multiplexer:
// FSM state encoding, channel-index width rule and the round-robin search.
package dvb_s2x_dec_frame_mux_pkg;

  // Largest channel count the round-robin search supports.
  localparam int cMAX_CHAN = 16;

  // Width of the channel tag carried on m_axis_tid.
  localparam int cTID_W = 8;

  // Frame FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PASS  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Channel index width: clog2 of the channel count, never below one bit.
  function automatic int chan_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First requesting channel searching upward from (last+1) mod n.
  // Returns last unchanged when nothing requests; callers gate on |req.
  function automatic logic [3:0] rr_next(input logic [15:0] req,
                                         input logic [3:0]  last,
                                         input int          n);
    logic       found;
    logic [4:0] idx;
    found   = 1'b0;
    rr_next = last;
    for (int i = 1; i <= cMAX_CHAN; i++) begin
      if (i <= n && !found) begin
        idx = 5'(last) + 5'(i);
        if (idx >= 5'(n)) idx = idx - 5'(n);
        if (req[idx[3:0]]) begin
          found   = 1'b1;
          rr_next = idx[3:0];
        end
      end
    end
  endfunction

endpackage

// File: rtl/dvb_s2x_axis_skid.sv
// Two-entry AXI-stream skid buffer with registered outputs.
// Handshake: a word moves on a cycle where valid and ready are both high;
// the producer must only assert in_valid when full is low, and the buffer
// holds out_valid/out_data stable while out_ready is low.
module dvb_s2x_axis_skid #(
  parameter int pW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [pW-1:0] in_data,
  output logic          full,
  output logic          empty,
  output logic          out_valid,
  output logic [pW-1:0] out_data,
  input  logic          out_ready
);

  logic [1:0]    cnt;
  logic [pW-1:0] skid_data;
  logic          pop;

  assign pop   = out_valid && out_ready;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  // Occupancy tracking: the output register is the head, skid_data the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            cnt       <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && pop) begin
            out_data <= in_data;
          end else if (in_valid) begin
            skid_data <= in_data;
            cnt       <= 2'd2;
          end else if (pop) begin
            out_valid <= 1'b0;
            cnt       <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            out_data <= skid_data;
            cnt      <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dvb_s2x_dec_frame_mux.sv
// Frame-level N-channel AXI-stream multiplexer feeding the decoder input.
// Round-robin grant at frame boundaries, lock until tlast, channel tag on
// tid, truncation of over-long frames with the remainder drained.
// Handshake: every s_axis/m_axis word transfers on a cycle where its valid
// and ready are both high; at most one s_axis_tready bit is ever high.
module dvb_s2x_dec_frame_mux
  import dvb_s2x_dec_frame_mux_pkg::*;
#(
  parameter int pN_CHAN  = 4,
  parameter int pDAT_W   = 32,
  parameter int pUSER_W  = 18,
  parameter int pDEST_W  = 4,
  parameter int pMAX_LEN = 4096
) (
  input  logic                        iclk,
  input  logic                        iresetn,
  input  logic [pN_CHAN-1:0]          s_axis_tvalid,
  input  logic [pN_CHAN*pDAT_W-1:0]   s_axis_tdata,
  input  logic [pN_CHAN-1:0]          s_axis_tlast,
  input  logic [pN_CHAN*pDEST_W-1:0]  s_axis_tdest,
  input  logic [pN_CHAN*pUSER_W-1:0]  s_axis_tuser,
  output logic [pN_CHAN-1:0]          s_axis_tready,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [pDAT_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [cTID_W-1:0]           m_axis_tid,
  output logic [pDEST_W-1:0]          m_axis_tdest,
  output logic [pUSER_W-1:0]          m_axis_tuser,
  output logic                        obusy,
  output logic                        oframe_done,
  output logic [cTID_W-1:0]           oframe_chan,
  output logic                        oframe_trunc,
  output logic [1:0]                  dbg_state
);

  localparam int cCHAN_W = chan_w(pN_CHAN);
  localparam int cCNT_W  = $clog2(pMAX_LEN + 1);
  localparam int cPKT_W  = 1 + cTID_W + pDEST_W + pUSER_W + pDAT_W;

  state_t               state;
  logic [cCHAN_W-1:0]   grant;
  logic [cCHAN_W-1:0]   last_grant;
  logic [cCHAN_W-1:0]   rr_grant;
  logic [cCNT_W-1:0]    wcnt;

  logic                 sel_valid;
  logic                 sel_last;
  logic [pDAT_W-1:0]    sel_data;
  logic [pDEST_W-1:0]   sel_dest;
  logic [pUSER_W-1:0]   sel_user;

  logic                 buf_full;
  logic                 buf_empty;
  logic                 accept;
  logic                 push;
  logic                 at_limit;
  logic [cPKT_W-1:0]    push_data;
  logic [cPKT_W-1:0]    pop_data;

  // Mux the granted channel's stream fields onto the internal select bus.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_dest  = '0;
    sel_user  = '0;
    for (int k = 0; k < pN_CHAN; k++) begin
      if (grant == cCHAN_W'(k)) begin
        sel_valid = s_axis_tvalid[k];
        sel_last  = s_axis_tlast[k];
        sel_data  = s_axis_tdata[k*pDAT_W +: pDAT_W];
        sel_dest  = s_axis_tdest[k*pDEST_W +: pDEST_W];
        sel_user  = s_axis_tuser[k*pUSER_W +: pUSER_W];
      end
    end
  end

  // Only the granted channel sees ready: gated by buffer space in PASS, always open in DRAIN.
  always_comb begin
    s_axis_tready = '0;
    for (int k = 0; k < pN_CHAN; k++) begin
      if (grant == cCHAN_W'(k)) begin
        s_axis_tready[k] = ((state == ST_PASS) && !buf_full) || (state == ST_DRAIN);
      end
    end
  end

  assign accept    = |(s_axis_tvalid & s_axis_tready);
  assign at_limit  = (wcnt == cCNT_W'(pMAX_LEN - 1));
  assign push      = accept && (state == ST_PASS);
  assign push_data = {sel_last | at_limit, cTID_W'(grant), sel_dest, sel_user, sel_data};
  assign rr_grant  = cCHAN_W'(rr_next(16'(s_axis_tvalid), 4'(last_grant), pN_CHAN));

  // Frame FSM: arbitrate in IDLE, forward in PASS, discard the overflow tail in DRAIN.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state        <= ST_IDLE;
      grant        <= '0;
      last_grant   <= cCHAN_W'(pN_CHAN - 1);
      wcnt         <= '0;
      oframe_done  <= 1'b0;
      oframe_trunc <= 1'b0;
      oframe_chan  <= '0;
    end else begin
      oframe_done  <= 1'b0;
      oframe_trunc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            grant <= rr_grant;
            state <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (accept) begin
            if (sel_last) begin
              oframe_done <= 1'b1;
              oframe_chan <= cTID_W'(grant);
              last_grant  <= grant;
              wcnt        <= '0;
              state       <= ST_IDLE;
            end else if (at_limit) begin
              oframe_done  <= 1'b1;
              oframe_trunc <= 1'b1;
              oframe_chan  <= cTID_W'(grant);
              wcnt         <= wcnt + 1'b1;
              state        <= ST_DRAIN;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && sel_last) begin
            last_grant <= grant;
            wcnt       <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dvb_s2x_axis_skid #(
    .pW (cPKT_W)
  ) u_skid (
    .clk       (iclk),
    .rst_n     (iresetn),
    .in_valid  (push),
    .in_data   (push_data),
    .full      (buf_full),
    .empty     (buf_empty),
    .out_valid (m_axis_tvalid),
    .out_data  (pop_data),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser, m_axis_tdata} = pop_data;
  assign obusy     = (state != ST_IDLE) || !buf_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_dvb_s2x_dec_frame_mux.sv
// Directed bench for dvb_s2x_dec_frame_mux: 4 channels, pMAX_LEN=16.
module tb_dvb_s2x_dec_frame_mux;

  localparam int NCH = 4;
  localparam int MAXL = 16;

  // ---------------- clock / reset ----------------
  logic iclk = 1'b0;
  logic iresetn;
  always #5 iclk = ~iclk;

  logic [NCH-1:0]    s_tvalid, s_tlast, s_tready;
  logic [NCH*32-1:0] s_tdata;
  logic [NCH*4-1:0]  s_tdest;
  logic [NCH*18-1:0] s_tuser;
  logic              m_tready, m_tvalid, m_tlast;
  logic [31:0]       m_tdata;
  logic [7:0]        m_tid;
  logic [3:0]        m_tdest;
  logic [17:0]       m_tuser;
  logic              obusy, fdone, ftrunc;
  logic [7:0]        fchan;
  logic [1:0]        st;

  dvb_s2x_dec_frame_mux #(
    .pN_CHAN (NCH), .pDAT_W (32), .pUSER_W (18), .pDEST_W (4), .pMAX_LEN (MAXL)
  ) dut (
    .iclk (iclk), .iresetn (iresetn),
    .s_axis_tvalid (s_tvalid), .s_axis_tdata (s_tdata), .s_axis_tlast (s_tlast),
    .s_axis_tdest (s_tdest), .s_axis_tuser (s_tuser), .s_axis_tready (s_tready),
    .m_axis_tready (m_tready), .m_axis_tvalid (m_tvalid), .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast), .m_axis_tid (m_tid), .m_axis_tdest (m_tdest),
    .m_axis_tuser (m_tuser), .obusy (obusy), .oframe_done (fdone),
    .oframe_chan (fchan), .oframe_trunc (ftrunc), .dbg_state (st)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [62:0] exp_q[$];
  logic [8:0]  done_q[$];

  logic [54:0] src_mem [NCH][64];
  int src_wr [NCH];
  int src_rd [NCH];
  int flush_gen = 0;
  int cyc = 0;
  logic bp_mode = 1'b0;
  logic ignore_out = 1'b0;

  int first_tv, first_mv, acc_total, max_run, run_acc;
  int drain_cyc, drain_bad, trunc_bad, onehot_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word layout in source memory: {last, user, dest, data}.
  function automatic logic [54:0] mk_word(input int ch, input int f, input int i, input logic last);
    logic [31:0] d;
    d = {ch[3:0], f[3:0], 8'h5A, i[15:0]};
    return {last, d[17:0] ^ 18'h2A5A5, 4'(ch + 5), d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_frame(input int ch, input int f, input int len);
    for (int i = 0; i < len; i++) begin
      src_mem[ch][src_wr[ch]] = mk_word(ch, f, i, (i == len - 1));
      src_wr[ch]++;
    end
  endtask

  // Expected output: first MAXL words, tlast on the real last or the forced limit word.
  task automatic expect_frame(input int ch, input int f, input int len);
    logic [54:0] w;
    logic lst;
    for (int i = 0; i < len && i < MAXL; i++) begin
      w = mk_word(ch, f, i, 1'b0);
      lst = (i == len - 1) || (i == MAXL - 1);
      exp_q.push_back({8'(ch), lst, w[35:32], w[53:36], w[31:0]});
    end
  endtask

  task automatic apply_reset();
    iresetn = 1'b0;
    flush_gen++;
    repeat (3) @(negedge iclk);
    iresetn = 1'b1;
    @(negedge iclk);
  endtask

  task automatic wait_idle();
    int n;
    logic empty;
    n = 0;
    do begin
      @(negedge iclk);
      n++;
      empty = 1'b1;
      for (int k = 0; k < NCH; k++) if (src_rd[k] != src_wr[k]) empty = 1'b0;
    end while (!(empty && !obusy && s_tvalid == '0) && n < 2000);
    chk("idle_timeout", 64'(n >= 2000), 64'd0);
    repeat (2) @(negedge iclk);
  endtask

  // Source model: accept decided mid-cycle, queues advance just after the edge.
  initial begin
    logic [NCH-1:0] fire;
    logic [54:0] w;
    int seen_gen;
    seen_gen = 0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tdest = '0; s_tuser = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge iclk);
      fire = s_tvalid & s_tready;
      @(posedge iclk);
      cyc++;
      #1;
      for (int k = 0; k < NCH; k++)
        if (fire[k] && src_rd[k] < src_wr[k]) src_rd[k]++;
      if (seen_gen != flush_gen) begin
        seen_gen = flush_gen;
        for (int k = 0; k < NCH; k++) src_rd[k] = src_wr[k];
      end
      for (int k = 0; k < NCH; k++) begin
        if (src_rd[k] < src_wr[k]) begin
          w = src_mem[k][src_rd[k]];
          s_tvalid[k] = 1'b1;
          s_tlast[k] = w[54];
          s_tuser[k*18 +: 18] = w[53:36];
          s_tdest[k*4 +: 4] = w[35:32];
          s_tdata[k*32 +: 32] = w[31:0];
        end else begin
          s_tvalid[k] = 1'b0;
          s_tlast[k] = 1'b0;
          s_tuser[k*18 +: 18] = '0;
          s_tdest[k*4 +: 4] = '0;
          s_tdata[k*32 +: 32] = '0;
        end
      end
      m_tready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end
  end

  // Monitor: output scoreboard, stall stability, done/trunc capture, ready rules.
  initial begin
    logic [62:0] cur, prev_word;
    logic prev_stall, acc_now;
    prev_stall = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge iclk);
      if (iresetn) begin
        cur = {m_tid, m_tlast, m_tdest, m_tuser, m_tdata};
        acc_now = |(s_tvalid & s_tready);
        if (acc_now) acc_total++;
        if (first_tv < 0 && |s_tvalid) first_tv = cyc;
        if (first_mv < 0 && m_tvalid) first_mv = cyc;
        if ($countones(s_tready) > 1) onehot_bad++;
        if (st == 2'd2) begin
          drain_cyc++;
          if (!s_tready[1]) drain_bad++;
        end
        if (!m_tready) begin
          if (acc_now) run_acc++;
          if (run_acc > max_run) max_run = run_acc;
        end else run_acc = 0;
        if (prev_stall) chk("stall_stable", 64'(cur), 64'(prev_word));
        prev_stall = m_tvalid && !m_tready;
        prev_word = cur;
        if (m_tvalid && m_tready && !ignore_out) begin
          if (exp_q.size() == 0) chk("extra_word", 64'(cur), 64'd0);
          else chk("out_word", 64'(cur), 64'(exp_q.pop_front()));
        end
        if (fdone) done_q.push_back({ftrunc, fchan});
        if (ftrunc && !fdone) trunc_bad++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, n;
    logic [8:0] rr_exp [5];
    first_tv = -1; first_mv = -1; acc_total = 0; max_run = 0; run_acc = 0;
    drain_cyc = 0; drain_bad = 0; trunc_bad = 0; onehot_bad = 0;
    iresetn = 1'b0;
    repeat (3) @(negedge iclk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_obusy", 64'(obusy), 64'd0);
    chk("rst_done", 64'(fdone), 64'd0);
    chk("rst_trunc", 64'(ftrunc), 64'd0);
    chk("rst_chan", 64'(fchan), 64'd0);
    chk("rst_m_fields", 64'({m_tlast, m_tid, m_tdest, m_tuser, m_tdata}), 64'd0);
    chk("rst_state", 64'(st), 64'd0);
    iresetn = 1'b1;
    @(negedge iclk);

    // Single channel: ch2, 8 words
    first_tv = -1; first_mv = -1; done_q.delete();
    expect_frame(2, 0, 8);
    load_frame(2, 0, 8);
    wait_idle();
    chk("t1_first_out_delay", 64'(first_mv - first_tv), 64'd2);
    chk("t1_words_left", 64'(exp_q.size()), 64'd0);
    chk("t1_done_count", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk("t1_done_chan", 64'(done_q[0]), 64'({1'b0, 8'd2}));

    // Round robin after reset: 0,1,2,3,0
    apply_reset();
    done_q.delete();
    expect_frame(0, 0, 4); expect_frame(1, 0, 4); expect_frame(2, 0, 4);
    expect_frame(3, 0, 4); expect_frame(0, 1, 4);
    load_frame(0, 0, 4); load_frame(0, 1, 4);
    load_frame(1, 0, 4); load_frame(2, 0, 4); load_frame(3, 0, 4);
    wait_idle();
    rr_exp[0] = 9'd0; rr_exp[1] = 9'd1; rr_exp[2] = 9'd2; rr_exp[3] = 9'd3; rr_exp[4] = 9'd0;
    chk("t2_words_left", 64'(exp_q.size()), 64'd0);
    chk("t2_done_count", 64'(done_q.size()), 64'd5);
    if (done_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("t2_grant_order", 64'(done_q[i]), 64'(rr_exp[i]));

    // Backpressure, 16-word frame on ch1 (tlast exactly at the length limit)
    done_q.delete(); bp_mode = 1'b1; max_run = 0; run_acc = 0; drain_cyc = 0;
    expect_frame(1, 0, 16);
    load_frame(1, 0, 16);
    wait_idle();
    bp_mode = 1'b0;
    chk("t3_words_left", 64'(exp_q.size()), 64'd0);
    chk("t3_done_count", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk("t3_no_trunc", 64'(done_q[0]), 64'({1'b0, 8'd1}));
    chk("t3_stall_accepts_le2", 64'(max_run <= 2), 64'd1);
    chk("t3_no_drain", 64'(drain_cyc), 64'd0);

    // Truncation: ch1 19-word frame, then a normal 3-word frame on ch1
    done_q.delete(); drain_cyc = 0; drain_bad = 0; trunc_bad = 0;
    expect_frame(1, 1, 19); expect_frame(1, 2, 3);
    load_frame(1, 1, 19); load_frame(1, 2, 3);
    wait_idle();
    chk("t4_words_left", 64'(exp_q.size()), 64'd0);
    chk("t4_done_count", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) begin
      chk("t4_trunc_done", 64'(done_q[0]), 64'({1'b1, 8'd1}));
      chk("t4_next_done", 64'(done_q[1]), 64'({1'b0, 8'd1}));
    end
    chk("t4_drain_cycles", 64'(drain_cyc), 64'd3);
    chk("t4_drain_ready", 64'(drain_bad), 64'd0);
    chk("t4_trunc_with_done", 64'(trunc_bad), 64'd0);

    // Reset mid-frame: ch3 8-word frame, reset after word 3
    ignore_out = 1'b1;
    base = acc_total;
    load_frame(3, 0, 8);
    n = 0;
    while (acc_total - base < 3 && n < 200) begin
      @(negedge iclk);
      n++;
    end
    chk("t5_wait_timeout", 64'(n >= 200), 64'd0);
    @(posedge iclk);
    #2;
    iresetn = 1'b0;
    flush_gen++;
    #1;
    chk("t5_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_s_tready", 64'(s_tready), 64'd0);
    chk("t5_obusy", 64'(obusy), 64'd0);
    chk("t5_state", 64'(st), 64'd0);
    chk("t5_m_fields", 64'({m_tlast, m_tid, m_tdest, m_tuser, m_tdata}), 64'd0);
    chk("t5_done_chan", 64'({fdone, ftrunc, fchan}), 64'd0);
    repeat (3) @(negedge iclk);
    exp_q.delete(); done_q.delete();
    iresetn = 1'b1;
    ignore_out = 1'b0;
    @(negedge iclk);
    expect_frame(0, 1, 2); expect_frame(3, 1, 2);
    load_frame(3, 1, 2); load_frame(0, 1, 2);
    wait_idle();
    chk("t5_words_left", 64'(exp_q.size()), 64'd0);
    chk("t5_done_count", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) begin
      chk("t5_first_grant", 64'(done_q[0]), 64'({1'b0, 8'd0}));
      chk("t5_second_grant", 64'(done_q[1]), 64'({1'b0, 8'd3}));
    end

    chk("tready_onehot", 64'(onehot_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls outside a bounded wait.
  initial begin
    #400000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
